// File: rtl/bus_rw_pkg.sv
// Shared types and constants for the bus read/write sequencer.
package bus_rw_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    localparam logic OE_ON  = 1'b1;
    localparam logic OE_OFF = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        TURN,
        RD_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/bus_wait_cnt.sv
// 4-bit loadable down-counter; done flags the last cycle of a wait (count==1).
module bus_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign done = (cnt == 4'd1);

endmodule

// File: rtl/bus_rw_master.sv
// Sequences writes/reads on a shared tri-state bus with one R/W* line,
// inserting turnaround guard cycles and optional write read-back.
//
// state   | meaning
// IDLE    | bus in READ, waiting for a request
// WR      | single bus-write cycle (target captures)
// TURN    | guard cycles after a write, bus released
// RD_WAIT | bus in READ, waiting for target data to settle
// RESP    | response presented until accepted
module bus_rw_master
    import bus_rw_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TURN_CYC  = 1,
    parameter int READ_WAIT = 2,
    parameter int VERIFY    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_rnw,
    output logic [DATA_W-1:0] bus_dout,
    output logic [DATA_W-1:0] bus_oe,
    input  logic [DATA_W-1:0] bus_din
);

    localparam logic [3:0] TURN_V = 4'(TURN_CYC);
    localparam logic [3:0] READ_V = 4'(READ_WAIT);
    localparam logic       VERIFY_B = (VERIFY != 0);
    localparam logic       HAS_TURN = (TURN_CYC > 0);

    state_t            state, next_state;
    logic              cnt_load;
    logic [3:0]        cnt_val;
    logic              cnt_en;
    logic              cnt_done;
    logic              wr_lat;
    logic [DATA_W-1:0] wdata_lat;

    bus_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = 4'd0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        next_state = WR;
                    end else begin
                        next_state = RD_WAIT;
                        cnt_load   = 1'b1;
                        cnt_val    = READ_V;
                    end
                end
            end
            WR: begin
                if (HAS_TURN) begin
                    next_state = TURN;
                    cnt_load   = 1'b1;
                    cnt_val    = TURN_V;
                end else if (VERIFY_B) begin
                    next_state = RD_WAIT;
                    cnt_load   = 1'b1;
                    cnt_val    = READ_V;
                end else begin
                    next_state = RESP;
                end
            end
            TURN: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    if (VERIFY_B) begin
                        next_state = RD_WAIT;
                        cnt_load   = 1'b1;
                        cnt_val    = READ_V;
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            RD_WAIT: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus controls are registered from next_state so rnw and oe flip on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rnw  <= BUS_READ;
            bus_oe   <= {DATA_W{OE_OFF}};
            bus_dout <= '0;
        end else begin
            bus_rnw <= (next_state == WR) ? BUS_WRITE : BUS_READ;
            bus_oe  <= (next_state == WR) ? {DATA_W{OE_ON}} : {DATA_W{OE_OFF}};
            if (next_state == WR) begin
                bus_dout <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_lat    <= 1'b0;
            wdata_lat <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if ((state == IDLE) && req_valid) begin
                wr_lat    <= req_write;
                wdata_lat <= req_wdata;
                rsp_err   <= 1'b0;
            end
            if ((state == RD_WAIT) && cnt_done) begin
                rsp_rdata <= bus_din;
                rsp_err   <= VERIFY_B & wr_lat & (bus_din != wdata_lat);
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

endmodule
